pt_write_buffer: RTL and testbench
==================================

PT_WRITE_BUFFER -- requirements
Module: pt_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, >=8).
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port frame_flag  input  1  new frame pulse; flushes any held pixel.
REQ-005 SHALL have port pt_pixel_write  input  18  pixel from projective transform.
REQ-006 SHALL have ports pt_x  input  10 and pt_y  input  9, destination coordinates of the pixel.
REQ-007 SHALL have port pt_wr  input  1  pixel valid strobe, one pixel per asserted cycle.
REQ-008 SHALL have port ptflag  output  1  ready; upstream may write on the cycle after it is seen high.
REQ-009 SHALL have port mem_addr  output  18  word address {pt_y, pt_x[9:1]}.
REQ-010 SHALL have port mem_data  output  36  [35:18] odd-x pixel, [17:0] even-x pixel.
REQ-011 SHALL have port mem_mask  output  2  bit0 even half valid, bit1 odd half valid.
REQ-012 SHALL have ports mem_we  output  1  entry valid, and mem_ready  input  1  memory accepts entry.
REQ-013 SHALL have ports drop_count  output  16 and overflow  output  1 (see Configuration).

Function
REQ-014 Pairing FSM SHALL have states IDLE and HOLD (even-x pixel held with its address).
REQ-015 IDLE, pt_wr with even x: store pixel and address, go HOLD; no push.
REQ-016 IDLE, pt_wr with odd x: push one entry, even half 0, mask 2'b10; stay IDLE.
REQ-017 HOLD, pt_wr with odd x and same address: push paired entry, mask 2'b11; go IDLE.
REQ-018 HOLD, pt_wr not pairing: push held entry, mask 2'b01; then apply REQ-015/016 to the new pixel in the same cycle (up to two pushes per cycle, held entry first).
REQ-019 frame_flag in HOLD without pt_wr SHALL push held entry mask 2'b01 and go IDLE; frame_flag with pt_wr SHALL push held entry and the new pixel per REQ-016 or push held and go IDLE discarding nothing (new even pixel then held afresh).
REQ-020 FIFO SHALL be first-in-first-out, accept 0/1/2 pushes and 1 pop per cycle simultaneously.
REQ-021 Head entry SHALL drive mem_addr/mem_data/mem_mask, mem_we=1 whenever FIFO non-empty; pop when mem_we && mem_ready.
REQ-022 Latency: entry pushed at edge N SHALL appear at outputs after edge N (show-ahead), if FIFO was empty.
REQ-023 ptflag SHALL be registered, high when free entries after current cycle >= 4, low otherwise.
REQ-024 A push finding FIFO full (after same-cycle pop) SHALL be dropped; existing entries unaffected.
REQ-025 Address field widths: no arithmetic beyond compare; pairing compare uses pt_y and pt_x[9:1].

Reset
REQ-026 reset_n low SHALL immediately clear FIFO, FSM to IDLE, mem_we=0, mem_addr/mem_data/mem_mask=0, ptflag=0, drop_count=0, overflow=0.
REQ-027 ptflag SHALL go high on first edge after reset_n release; held pixel lost on mid-operation reset.

Configuration
REQ-028 With PT_WB_STATS_EN defined, drop_count SHALL count dropped entries saturating at 16'hFFFF and overflow SHALL go sticky-high on first drop until reset.
REQ-029 Without PT_WB_STATS_EN, drop_count and overflow SHALL be constant 0 and no counter logic built; dropping behaviour unchanged.

Verification
REQ-030 Writes x=0..3,y=5 consecutive, mem_ready=1 -> two entries addr {5,0},{5,1}, mask 11, data {px1,px0},{px3,px2}.
REQ-031 Write x=4 then x=8 same y -> entry addr x>>1=2 mask 01, x=8 held; frame_flag -> entry addr 4 mask 01.
REQ-032 Write x=7 from IDLE -> one entry addr x>>1=3 mask 10, data[17:0]=0.
REQ-033 mem_ready=0, unpaired odd writes each cycle -> ptflag falls when free<4; forcing 20 writes with DEPTH=16 -> 4 drops, drop_count=4, overflow=1 (macro on), both 0 (macro off).
REQ-034 HOLD x=2 then write x=5 -> two pushes same cycle, order addr 1 mask 01 then addr 2 mask 10.
REQ-035 reset_n low mid-burst with 5 entries queued -> mem_we=0 asynchronously, FIFO empty, ptflag high one edge after release.

Source files
------------

// File: rtl/pt_write_buffer.sv
// Pairs even/odd-x pixels from the projective transform into 36-bit memory words and queues them in a show-ahead FIFO.
// Optional statistics (drop_count/overflow) are built only when PT_WB_STATS_EN is defined.
module pt_write_buffer #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_flag,
    input  logic [17:0] pt_pixel_write,
    input  logic [9:0]  pt_x,
    input  logic [8:0]  pt_y,
    input  logic        pt_wr,
    output logic        ptflag,
    output logic [17:0] mem_addr,
    output logic [35:0] mem_data,
    output logic [1:0]  mem_mask,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [15:0] drop_count,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 56;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [17:0]     r_hold_pix;
    logic [17:0]     r_hold_addr;
    logic            w_load_hold;

    // Entry layout: [55:38] address, [37:2] data {odd, even}, [1:0] mask.
    logic            w_push_a;
    logic            w_push_b;
    logic [EW-1:0]   w_entry_a;
    logic [EW-1:0]   w_entry_b;
    logic [17:0]     w_new_addr;
    logic            w_new_odd;
    logic            w_pairs;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_ptflag;

    logic            w_pop;
    logic [CW:0]     w_free;
    logic            w_acc_a;
    logic            w_acc_b;
    logic [CW-1:0]   w_count_nxt;
    logic            w_ptflag_nxt;
    logic [EW-1:0]   w_head;
    logic            w_nonempty;

    assign w_new_addr = {pt_y, pt_x[9:1]};
    assign w_new_odd  = pt_x[0];
    // A frame boundary never pairs: the held pixel is flushed before the new one is considered.
    assign w_pairs    = pt_wr && w_new_odd && !frame_flag && (w_new_addr == r_hold_addr);

    // Pairing stage: decide up to two pushes, held entry always in slot A.
    always_comb begin
        w_state_nxt = r_state;
        w_load_hold = 1'b0;
        w_push_a    = 1'b0;
        w_push_b    = 1'b0;
        w_entry_a   = '0;
        w_entry_b   = '0;
        case (r_state)
            S_IDLE: begin
                if (pt_wr) begin
                    if (w_new_odd) begin
                        w_push_a  = 1'b1;
                        w_entry_a = {w_new_addr, pt_pixel_write, 18'd0, 2'b10};
                    end else begin
                        w_load_hold = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_pairs) begin
                    w_push_a    = 1'b1;
                    w_entry_a   = {r_hold_addr, pt_pixel_write, r_hold_pix, 2'b11};
                    w_state_nxt = S_IDLE;
                end else if (pt_wr) begin
                    w_push_a  = 1'b1;
                    w_entry_a = {r_hold_addr, 18'd0, r_hold_pix, 2'b01};
                    if (w_new_odd) begin
                        w_push_b    = 1'b1;
                        w_entry_b   = {w_new_addr, pt_pixel_write, 18'd0, 2'b10};
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_load_hold = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (frame_flag) begin
                    w_push_a    = 1'b1;
                    w_entry_a   = {r_hold_addr, 18'd0, r_hold_pix, 2'b01};
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_hold) begin
            r_hold_pix  <= pt_pixel_write;
            r_hold_addr <= w_new_addr;
        end
    end

    // FIFO stage: free space accounts for the same-cycle pop before pushes are admitted.
    assign w_nonempty   = (r_count != '0);
    assign w_pop        = w_nonempty && mem_ready;
    assign w_free       = (CW+1)'(DEPTH) - {1'b0, r_count} + (CW+1)'(w_pop);
    assign w_acc_a      = w_push_a && (w_free != '0);
    assign w_acc_b      = w_push_b && (w_free > (CW+1)'(w_acc_a));
    assign w_count_nxt  = r_count - CW'(w_pop) + CW'(w_acc_a) + CW'(w_acc_b);
    assign w_ptflag_nxt = (((CW+1)'(DEPTH) - {1'b0, w_count_nxt}) >= (CW+1)'(4));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ptflag <= 1'b0;
        end else begin
            r_wptr   <= r_wptr + AW'(w_acc_a) + AW'(w_acc_b);
            r_rptr   <= r_rptr + AW'(w_pop);
            r_count  <= w_count_nxt;
            r_ptflag <= w_ptflag_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc_a) begin
            r_mem[r_wptr] <= w_entry_a;
        end
        if (w_acc_b) begin
            r_mem[r_wptr + AW'(w_acc_a)] <= w_entry_b;
        end
    end

    // Output stage: head entry shown directly, zeroed while empty so reset clears it at once.
    assign w_head   = r_mem[r_rptr];
    assign mem_we   = w_nonempty;
    assign mem_addr = w_nonempty ? w_head[55:38] : 18'd0;
    assign mem_data = w_nonempty ? w_head[37:2]  : 36'd0;
    assign mem_mask = w_nonempty ? w_head[1:0]   : 2'd0;
    assign ptflag   = r_ptflag;

`ifdef PT_WB_STATS_EN
    logic [1:0]  w_drops;
    logic [15:0] r_drop_count;
    logic        r_overflow;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign w_drops = {1'b0, (w_push_a && !w_acc_a)} + {1'b0, (w_push_b && !w_acc_b)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= 16'd0;
            r_overflow   <= 1'b0;
        end else begin
            r_drop_count <= sat_add16(r_drop_count, w_drops);
            if (w_drops != 2'd0) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;
`else
    assign drop_count = 16'd0;
    assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_pt_write_buffer.sv
// Directed bench for pt_write_buffer: queue-based reference model compared every cycle, plus literal spot checks.
module tb_pt_write_buffer;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_flag;
    logic [17:0] pt_pixel_write;
    logic [9:0]  pt_x;
    logic [8:0]  pt_y;
    logic        pt_wr;
    logic        ptflag;
    logic [17:0] mem_addr;
    logic [35:0] mem_data;
    logic [1:0]  mem_mask;
    logic        mem_we;
    logic        mem_ready;
    logic [15:0] drop_count;
    logic        overflow;

    pt_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .frame_flag(frame_flag),
        .pt_pixel_write(pt_pixel_write), .pt_x(pt_x), .pt_y(pt_y), .pt_wr(pt_wr),
        .ptflag(ptflag), .mem_addr(mem_addr), .mem_data(mem_data), .mem_mask(mem_mask),
        .mem_we(mem_we), .mem_ready(mem_ready), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: words as {addr, odd, even, mask}; held pixel tracked as a flag.
    logic [55:0] q_m[$];
    logic [55:0] p_m[$];
    logic        held_v;
    logic [17:0] held_pix;
    logic [17:0] held_addr;
    logic        ptflag_m;
    int          drops_m;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_m.delete();
            held_v   = 1'b0;
            ptflag_m = 1'b0;
            drops_m  = 0;
        end else begin
            logic [17:0] na;
            logic        used;
            na   = {pt_y, pt_x[9:1]};
            used = 1'b0;
            p_m.delete();
            if (q_m.size() > 0 && mem_ready) void'(q_m.pop_front());
            if (held_v) begin
                if (pt_wr && !frame_flag && pt_x[0] && na == held_addr) begin
                    p_m.push_back({held_addr, pt_pixel_write, held_pix, 2'b11});
                    used   = 1'b1;
                    held_v = 1'b0;
                end else if (pt_wr || frame_flag) begin
                    p_m.push_back({held_addr, 18'd0, held_pix, 2'b01});
                    held_v = 1'b0;
                end
            end
            if (pt_wr && !used) begin
                if (pt_x[0]) p_m.push_back({na, pt_pixel_write, 18'd0, 2'b10});
                else begin
                    held_v    = 1'b1;
                    held_pix  = pt_pixel_write;
                    held_addr = na;
                end
            end
            foreach (p_m[i]) begin
                if (q_m.size() < DEPTH) q_m.push_back(p_m[i]);
                else drops_m++;
            end
            ptflag_m = (DEPTH - q_m.size()) >= 4;
        end
    end

    always @(negedge clk) begin
        logic [15:0] dc_exp;
        logic        ov_exp;
`ifdef PT_WB_STATS_EN
        dc_exp = (drops_m > 65535) ? 16'hFFFF : 16'(drops_m);
        ov_exp = (drops_m > 0);
`else
        dc_exp = 16'd0;
        ov_exp = 1'b0;
`endif
        chk("mdl_we", mem_we, q_m.size() != 0);
        if (q_m.size() != 0) begin
            chk("mdl_addr", mem_addr, q_m[0][55:38]);
            chk("mdl_data", mem_data, q_m[0][37:2]);
            chk("mdl_mask", mem_mask, q_m[0][1:0]);
        end else begin
            chk("mdl_addr0", mem_addr, 0);
            chk("mdl_mask0", mem_mask, 0);
        end
        chk("mdl_ptflag", ptflag, ptflag_m);
        chk("mdl_drop_count", drop_count, dc_exp);
        chk("mdl_overflow", overflow, ov_exp);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int x, input int y, input logic [17:0] pix, input logic ff);
        cyc();
        pt_wr          = 1'b1;
        pt_x           = 10'(x);
        pt_y           = 9'(y);
        pt_pixel_write = pix;
        frame_flag     = ff;
    endtask

    task automatic idle();
        cyc();
        pt_wr      = 1'b0;
        frame_flag = 1'b0;
    endtask

    task automatic pop_one();
        cyc();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        idle();
        mem_ready = 1'b1;
        repeat (20) cyc();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("drain_empty", mem_we, 1'b0);
    endtask

    initial begin
        reset_n        = 1'b0;
        frame_flag     = 1'b0;
        pt_pixel_write = '0;
        pt_x           = '0;
        pt_y           = '0;
        pt_wr          = 1'b0;
        mem_ready      = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_ptflag", ptflag, 1'b0);
        chk("rst_drop", drop_count, 16'd0);
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_ptflag_before_edge", ptflag, 1'b0);
        @(negedge clk);
        chk("rel_ptflag_after_edge", ptflag, 1'b1);

        // x=0..3 on row 5 become two paired words
        wr(0, 5, 18'h0A0A0, 1'b0);
        wr(1, 5, 18'h1B1B1, 1'b0);
        wr(2, 5, 18'h2C2C2, 1'b0);
        wr(3, 5, 18'h3D3D3, 1'b0);
        idle();
        @(negedge clk);
        chk("pair0_addr", mem_addr, 18'h00A00);
        chk("pair0_data", mem_data, {18'h1B1B1, 18'h0A0A0});
        chk("pair0_mask", mem_mask, 2'b11);
        pop_one();
        chk("pair1_addr", mem_addr, 18'h00A01);
        chk("pair1_data", mem_data, {18'h3D3D3, 18'h2C2C2});
        chk("pair1_mask", mem_mask, 2'b11);
        drain();

        // x=4 then x=8: lone even flushed, x=8 held until frame_flag
        wr(4, 3, 18'h04444, 1'b0);
        wr(8, 3, 18'h08888, 1'b0);
        idle();
        @(negedge clk);
        chk("even_addr", mem_addr, 18'h00602);
        chk("even_mask", mem_mask, 2'b01);
        chk("even_data", mem_data, {18'd0, 18'h04444});
        cyc();
        frame_flag = 1'b1;
        cyc();
        frame_flag = 1'b0;
        pop_one();
        chk("ff_addr", mem_addr, 18'h00604);
        chk("ff_mask", mem_mask, 2'b01);
        chk("ff_data", mem_data, {18'd0, 18'h08888});
        drain();

        // lone odd x=7
        wr(7, 1, 18'h07777, 1'b0);
        idle();
        @(negedge clk);
        chk("odd_addr", mem_addr, 18'h00203);
        chk("odd_mask", mem_mask, 2'b10);
        chk("odd_even_half", mem_data[17:0], 18'd0);
        drain();

        // held x=2 then x=5: two pushes in one cycle
        wr(2, 0, 18'h12222, 1'b0);
        wr(5, 0, 18'h15555, 1'b0);
        idle();
        @(negedge clk);
        chk("dual0_addr", mem_addr, 18'h00001);
        chk("dual0_mask", mem_mask, 2'b01);
        pop_one();
        chk("dual1_addr", mem_addr, 18'h00002);
        chk("dual1_mask", mem_mask, 2'b10);
        chk("dual1_data", mem_data, {18'h15555, 18'd0});
        drain();

        // 20 unpaired odd writes into a 16-deep stalled FIFO
        for (int i = 0; i < 20; i++) wr(2 * i + 1, 7, 18'(i + 100), 1'b0);
        idle();
        @(negedge clk);
        chk("full_ptflag", ptflag, 1'b0);
        chk("full_we", mem_we, 1'b1);
`ifdef PT_WB_STATS_EN
        chk("full_drop_count", drop_count, 16'd4);
        chk("full_overflow", overflow, 1'b1);
`else
        chk("full_drop_count", drop_count, 16'd0);
        chk("full_overflow", overflow, 1'b0);
`endif
        chk("full_head_addr", mem_addr, 18'h00E00);
        drain();

        // reset mid-burst with 5 queued and one pixel held
        for (int i = 0; i < 5; i++) wr(2 * i + 1, 9, 18'(i + 200), 1'b0);
        wr(10, 2, 18'h3FFFF, 1'b0);
        idle();
        @(negedge clk);
        chk("pre_rst_we", mem_we, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_we", mem_we, 1'b0);
        chk("async_addr", mem_addr, 18'd0);
        chk("async_ptflag", ptflag, 1'b0);
        cyc();
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel2_ptflag_before", ptflag, 1'b0);
        @(negedge clk);
        chk("rel2_ptflag_after", ptflag, 1'b1);
        cyc();
        frame_flag = 1'b1;
        cyc();
        frame_flag = 1'b0;
        @(negedge clk);
        chk("held_lost", mem_we, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
